// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of mem_arbiter, bundled as one interface.
// master = requesters plus memory (environment side), slave = the arbiter itself.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              p0_req;
  logic              p0_wr;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_done;
  logic              p0_err;

  logic              p1_req;
  logic              p1_wr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_done;
  logic              p1_err;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_err;

  logic              busy;
  logic              timeout_flag;

  modport master (
    output p0_req, p0_wr, p0_addr, p0_wdata,
    input  p0_rdata, p0_done, p0_err,
    output p1_req, p1_wr, p1_addr, p1_wdata,
    input  p1_rdata, p1_done, p1_err,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err,
    input  busy, timeout_flag
  );

  modport slave (
    input  p0_req, p0_wr, p0_addr, p0_wdata,
    output p0_rdata, p0_done, p0_err,
    input  p1_req, p1_wr, p1_addr, p1_wdata,
    output p1_rdata, p1_done, p1_err,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err,
    output busy, timeout_flag
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported stalling memory, with stall timeout.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined; fixed priority (port 1 first) otherwise.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              pick;
  logic              finish;
  logic              abort;
  logic [DATA_W-1:0] rd_word;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              other_req;

  // Live fields of the granted port, and whether the other port is waiting
  always_comb begin
    if (grant_q) begin
      sel_wr    = bus.p1_wr;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
      other_req = bus.p0_req;
    end else begin
      sel_wr    = bus.p0_wr;
      sel_addr  = bus.p0_addr;
      sel_wdata = bus.p0_wdata;
      other_req = bus.p1_req;
    end
  end

`ifdef MEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;

  always_comb pick = (bus.p0_req && bus.p1_req) ? ~rr_last_q : bus.p1_req;
`else
  always_comb pick = bus.p1_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q  <= rr_last_d;
`endif
    end
  end

  // Next state and memory/done outputs; everything is held quiet while rst is high
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d     = rr_last_q;
`endif
    finish        = 1'b0;
    abort         = 1'b0;
    rd_word       = '0;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.p0_done   = 1'b0;
    bus.p0_rdata  = '0;
    bus.p0_err    = 1'b0;
    bus.p1_done   = 1'b0;
    bus.p1_rdata  = '0;
    bus.p1_err    = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.p0_req || bus.p1_req) begin
            state_d    = BUSY;
            grant_d    = pick;
            wait_cnt_d = '0;
          end
        end

        BUSY: begin
          bus.mem_en    = 1'b1;
          bus.mem_wr    = sel_wr;
          bus.mem_addr  = sel_addr;
          bus.mem_wdata = sel_wdata;

          // A ready on the timeout boundary still counts as a normal completion
          if (bus.mem_ready) begin
            finish = 1'b1;
          end else if (wait_cnt_q == CNT_LAST) begin
            finish    = 1'b1;
            abort     = 1'b1;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end

          if (finish) begin
            rd_word = (abort || sel_wr) ? '0 : bus.mem_rdata;
            if (grant_q) begin
              bus.p1_done  = 1'b1;
              bus.p1_rdata = rd_word;
              bus.p1_err   = abort | bus.mem_err;
            end else begin
              bus.p0_done  = 1'b1;
              bus.p0_rdata = rd_word;
              bus.p0_err   = abort | bus.mem_err;
            end
`ifdef MEM_ARB_RR_EN
            rr_last_d = grant_q;
`endif
            // Hand straight over to a waiting port; the completing port's req is ignored here
            if (other_req) begin
              grant_d    = ~grant_q;
              wait_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy         = (state_q == BUSY);
  assign bus.timeout_flag = timeout_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported, stalling 16-bit memory (64K bytes, word-aligned, combinational read, `ready` qualifies each access).
- Port 0 is instruction fetch; port 1 is data memory.
- Grants one requester at a time and holds the memory request until `ready` returns.
- Returns a one-cycle done pulse with read data and error, and aborts accesses that stall too long.

Parameters:
- ADDR_W, 16, address width for ports and memory.
- DATA_W, 16, data width.
- TIMEOUT, 64, number of consecutive ready-low BUSY cycles before the access is aborted (valid range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- p0_req  in  1  port 0 request; held with its fields until p0_done
- p0_wr  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 byte address
- p0_wdata  in  DATA_W  port 0 write data
- p0_rdata  out  DATA_W  port 0 read data; valid only while p0_done=1
- p0_done  out  1  port 0 completion pulse
- p0_err  out  1  port 0 error (misaligned or timeout), qualified by p0_done
- p1_req, p1_wr, p1_addr, p1_wdata, p1_rdata, p1_done, p1_err: same as port 0, for port 1
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational)
- mem_ready  in  1  memory accepted the access this cycle
- mem_err  in  1  memory misaligned-access error
- busy  out  1  state is BUSY
- timeout_flag  out  1  sticky: set on any timeout abort, cleared only by rst

Behaviour:
- State machine: IDLE, BUSY. Registers: state, grant (0/1), wait_cnt (8 bits), rr_last (used only with the optional feature), timeout_flag.
- Reset: state=IDLE, grant=0, wait_cnt=0, rr_last=1, timeout_flag=0. While rst=1, mem_en=0 and both done outputs are 0; no memory write may occur.
- Outputs in IDLE: mem_en=0, done=0, rdata=0, err=0. mem_wr/mem_addr/mem_wdata are don't-care but driven 0.
- IDLE transitions:
  - Any req → BUSY next cycle; grant is registered from the arbitration result and wait_cnt=0.
  - Fixed priority: port 1 (data) wins over port 0.
  - No combinational path from req to mem_en, so the minimum latency from req to done is 1 cycle.
- BUSY outputs:
  - mem_en=1; mem_wr/mem_addr/mem_wdata are muxed combinationally from the granted port's live inputs.
  - The requester must hold its fields stable; the ungranted port has no effect.
- BUSY completion (mem_ready=1):
  - Granted done=1 and rdata=mem_rdata; for writes rdata=0. err=mem_err. The memory write commits at this edge.
- BUSY next state after completion:
  - If the other port's req=1 in the completion cycle → stay BUSY, grant flips to it, wait_cnt=0 (back-to-back, no idle bubble).
  - Otherwise → IDLE.
  - The completing port's req is ignored at the completion edge. It must drop req the cycle after done; a req still high in IDLE is treated as a new request.
- BUSY stall (mem_ready=0): wait_cnt increments.
- Timeout: if wait_cnt==TIMEOUT-1 and mem_ready=0, abort that cycle.
  - Granted done=1, err=1, rdata=0, timeout_flag set.
  - Next state follows the same rule as completion. No write occurs, because mem_ready is 0.
- Simultaneous mem_ready=1 and the timeout boundary: completion wins and no timeout is recorded.
- The err output is valid only while done=1.
- Reset mid-access returns the block to IDLE with no done pulse; the requester must reissue its request.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both ports request in IDLE, or at a back-to-back decision, grant goes to the port other than rr_last.
  - rr_last updates to the granted port on every completion or abort.
- Undefined: fixed priority, port 1 over port 0. rr_last is not implemented.

Test Plan:
- Single read, memory ready: p0 read addr 0x0010, mem_ready=1 in the first BUSY cycle, mem_rdata=0xBEEF → p0_done=1 one cycle after req with p0_rdata=0xBEEF, p0_err=0; state returns to IDLE.
- Stalled write: p1 write addr 0x0100 data 0x1234, mem_ready low for 3 cycles then high → mem_en=1 for 4 cycles with mem_addr=0x0100, mem_wdata=0x1234, mem_wr=1; p1_done pulses on the 4th BUSY cycle only.
- Contention: p0 and p1 both request in the same cycle, mem_ready=1 always → without MEM_ARB_RR_EN, p1 is done at cycle +1 and p0 at cycle +2 (back-to-back, no IDLE); with MEM_ARB_RR_EN after reset, p0 is served first.
- Timeout: p0 read with mem_ready held 0 and TIMEOUT=4 → p0_done=1 with p0_err=1 on the 4th BUSY cycle; timeout_flag=1 and stays 1 until rst.
- Misaligned access: p1 read addr 0x0003, mem_ready=1, mem_err=1 → p1_done=1, p1_err=1, timeout_flag unchanged.
- Reset mid-access: rst asserted during the 2nd stalled BUSY cycle → next cycle state=IDLE, mem_en=0, no done pulse, busy=0.
